alu_zb_pipe: RTL and testbench

Parametrised, two-stage pipelined integer ALU for the execute stage of the RV64I/Zba core; next generation of the combinational Zba ALU. Adds XLEN genericity (32/64), a valid/ready handshake with back-pressure, a destination-tag sideband, a synchronous flush, and base/W/Zbb-count operations. Sits between the ID/EX register and the EX/MEM forwarding path. Sustains one operation per cycle.

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_zb_count.sv | 37 +++
 rtl/alu_zb_pipe.sv | 166 ++++++++++++++++
 tb/tb_alu_zb_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and legality helpers for the pipelined Zba/Zbb ALU.
// Honours ALU_ZBB_COUNT_EN: when undefined, CLZ/CTZ/CPOP decode as illegal.
package alu_pkg;

  typedef enum logic [4:0] {
    OpAdd      = 5'd0,
    OpSub      = 5'd1,
    OpAnd      = 5'd2,
    OpOr       = 5'd3,
    OpSh1add   = 5'd4,
    OpSh2add   = 5'd5,
    OpSh3add   = 5'd6,
    OpAddUw    = 5'd7,
    OpSh1addUw = 5'd8,
    OpSh2addUw = 5'd9,
    OpSh3addUw = 5'd10,
    OpSlliUw   = 5'd11,
    OpXor      = 5'd12,
    OpSll      = 5'd13,
    OpSrl      = 5'd14,
    OpSra      = 5'd15,
    OpSlt      = 5'd16,
    OpSltu     = 5'd17,
    OpClz      = 5'd18,
    OpCtz      = 5'd19,
    OpCpop     = 5'd20,
    OpAddw     = 5'd21,
    OpSubw     = 5'd22
  } alu_op_e;

`ifdef ALU_ZBB_COUNT_EN
  localparam bit ZbbCountEn = 1'b1;
`else
  localparam bit ZbbCountEn = 1'b0;
`endif

  function automatic bit xlen_is_valid(int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  function automatic logic is_legal(logic [4:0] op, int unsigned xlen);
    logic legal;
    legal = (op <= OpSubw);
    // The _UW and W forms only exist on a 64-bit datapath.
    if (xlen == 32) begin
      if ((op >= OpAddUw && op <= OpSlliUw) || op == OpAddw || op == OpSubw) begin
        legal = 1'b0;
      end
    end
    if (!ZbbCountEn && op >= OpClz && op <= OpCpop) begin
      legal = 1'b0;
    end
    return legal;
  endfunction

endpackage

// File: rtl/alu_zb_count.sv
// Combinational leading-zero, trailing-zero and population count of one operand.
// Only instantiated when ALU_ZBB_COUNT_EN is defined.
module alu_zb_count #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]         a_i,
  output logic [$clog2(XLEN):0]   clz_o,
  output logic [$clog2(XLEN):0]   ctz_o,
  output logic [$clog2(XLEN):0]   cpop_o
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  // Scanning upward leaves the count set by the most significant one.
  always_comb begin
    clz_o = CntW'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (a_i[i]) clz_o = CntW'(XLEN - 1 - i);
    end
  end

  // Scanning downward leaves the count set by the least significant one.
  always_comb begin
    ctz_o = CntW'(XLEN);
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (a_i[i]) ctz_o = CntW'(i);
    end
  end

  always_comb begin
    cpop_o = '0;
    for (int i = 0; i < XLEN; i++) begin
      cpop_o = cpop_o + CntW'(a_i[i]);
    end
  end

endmodule

// File: rtl/alu_zb_pipe.sv
// Two-stage valid/ready pipelined RV64I/Zba ALU with tag sideband and flush.
// Define ALU_ZBB_COUNT_EN to implement CLZ/CTZ/CPOP via alu_zb_count.
module alu_zb_pipe
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [XLEN-1:0]  SrcA,
  input  logic [XLEN-1:0]  SrcB,
  input  logic [4:0]       ALUControl,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [XLEN-1:0]  ALUResult,
  output logic             Zero,
  output logic             Illegal,
  output logic [TAG_W-1:0] OutTag
);

  localparam int unsigned ShW = $clog2(XLEN);

  if (!xlen_is_valid(XLEN)) begin : gen_bad_xlen
    $error("alu_zb_pipe: XLEN must be 32 or 64");
  end

  logic             s1_valid_q;
  logic [XLEN-1:0]  s1_a_q;
  logic [XLEN-1:0]  s1_b_q;
  logic [4:0]       s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [XLEN-1:0]  s2_res_q;
  logic             s2_zero_q;
  logic             s2_ill_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             s2_load;
  logic             accept;
  logic             legal;
  logic [XLEN-1:0]  res_d;

  assign s2_load = s1_valid_q && (!s2_valid_q || OutReady);
  // rst_n gating keeps InReady low for the whole reset window.
  assign InReady = rst_n && !Flush && (!s1_valid_q || s2_load);
  assign accept  = InValid && InReady;

`ifdef ALU_ZBB_COUNT_EN
  logic [ShW:0] clz;
  logic [ShW:0] ctz;
  logic [ShW:0] cpop;

  alu_zb_count #(
    .XLEN (XLEN)
  ) u_count (
    .a_i    (s1_a_q),
    .clz_o  (clz),
    .ctz_o  (ctz),
    .cpop_o (cpop)
  );
`endif

  always_comb begin
    logic [XLEN-1:0] a_uw;
    logic [ShW-1:0]  shamt;
    logic [31:0]     w32;

    a_uw        = '0;
    a_uw[31:0]  = s1_a_q[31:0];
    shamt       = s1_b_q[ShW-1:0];
    w32         = '0;
    res_d       = '0;
    legal       = is_legal(s1_op_q, XLEN);

    case (s1_op_q)
      OpAdd:      res_d = s1_a_q + s1_b_q;
      OpSub:      res_d = s1_a_q - s1_b_q;
      OpAnd:      res_d = s1_a_q & s1_b_q;
      OpOr:       res_d = s1_a_q | s1_b_q;
      OpSh1add:   res_d = s1_b_q + (s1_a_q << 1);
      OpSh2add:   res_d = s1_b_q + (s1_a_q << 2);
      OpSh3add:   res_d = s1_b_q + (s1_a_q << 3);
      OpAddUw:    res_d = s1_b_q + a_uw;
      OpSh1addUw: res_d = s1_b_q + (a_uw << 1);
      OpSh2addUw: res_d = s1_b_q + (a_uw << 2);
      OpSh3addUw: res_d = s1_b_q + (a_uw << 3);
      OpSlliUw:   res_d = a_uw << s1_b_q[5:0];
      OpXor:      res_d = s1_a_q ^ s1_b_q;
      OpSll:      res_d = s1_a_q << shamt;
      OpSrl:      res_d = s1_a_q >> shamt;
      OpSra:      res_d = $signed(s1_a_q) >>> shamt;
      OpSlt:      res_d[0] = $signed(s1_a_q) < $signed(s1_b_q);
      OpSltu:     res_d[0] = s1_a_q < s1_b_q;
`ifdef ALU_ZBB_COUNT_EN
      OpClz:      res_d = XLEN'(clz);
      OpCtz:      res_d = XLEN'(ctz);
      OpCpop:     res_d = XLEN'(cpop);
`endif
      OpAddw: begin
        w32        = s1_a_q[31:0] + s1_b_q[31:0];
        res_d      = {XLEN{w32[31]}};
        res_d[31:0] = w32;
      end
      OpSubw: begin
        w32        = s1_a_q[31:0] - s1_b_q[31:0];
        res_d      = {XLEN{w32[31]}};
        res_d[31:0] = w32;
      end
      default:    res_d = '0;
    endcase

    if (!legal) res_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_ill_q   <= 1'b0;
      s2_tag_q   <= '0;
    end else if (Flush) begin
      // Data registers are left stale; only the valid bits matter.
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_q <= 1'b1;
        s2_res_q   <= res_d;
        s2_zero_q  <= (res_d == '0);
        s2_ill_q   <= !legal;
        s2_tag_q   <= s1_tag_q;
      end else if (OutReady) begin
        s2_valid_q <= 1'b0;
      end

      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= SrcA;
        s1_b_q     <= SrcB;
        s1_op_q    <= ALUControl;
        s1_tag_q   <= InTag;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  assign OutValid  = s2_valid_q;
  assign ALUResult = s2_res_q;
  assign Zero      = s2_zero_q;
  assign Illegal   = s2_ill_q;
  assign OutTag    = s2_tag_q;

endmodule

// File: tb/tb_alu_zb_pipe.sv
// Directed self-checking bench for alu_zb_pipe (XLEN=64 main instance, XLEN=32 side instance).
// Count-op expectations follow ALU_ZBB_COUNT_EN.
module tb_alu_zb_pipe;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src_a;
  logic [63:0] src_b;
  logic [4:0]  op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        illegal;
  logic [4:0]  out_tag;

  logic        v32_in_valid;
  logic        v32_in_ready;
  logic [31:0] v32_a;
  logic [31:0] v32_b;
  logic [4:0]  v32_op;
  logic [4:0]  v32_in_tag;
  logic        v32_out_valid;
  logic [31:0] v32_result;
  logic        v32_zero;
  logic        v32_illegal;
  logic [4:0]  v32_out_tag;

  int errors = 0;
  int checks = 0;

  alu_zb_pipe #(.XLEN(64), .TAG_W(5)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Flush      (flush),
    .InValid    (in_valid),
    .InReady    (in_ready),
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUControl (op),
    .InTag      (in_tag),
    .OutValid   (out_valid),
    .OutReady   (out_ready),
    .ALUResult  (result),
    .Zero       (zero),
    .Illegal    (illegal),
    .OutTag     (out_tag)
  );

  alu_zb_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .Flush      (1'b0),
    .InValid    (v32_in_valid),
    .InReady    (v32_in_ready),
    .SrcA       (v32_a),
    .SrcB       (v32_b),
    .ALUControl (v32_op),
    .InTag      (v32_in_tag),
    .OutValid   (v32_out_valid),
    .OutReady   (1'b1),
    .ALUResult  (v32_result),
    .Zero       (v32_zero),
    .Illegal    (v32_illegal),
    .OutTag     (v32_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] t);
    op     = o;
    src_a  = a;
    src_b  = b;
    in_tag = t;
  endtask

  task automatic chk_out(input string name, input logic [63:0] exp, input logic exp_ill,
                         input logic [4:0] exp_tag);
    chk1({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_res"}, result, exp);
    chk1({name, "_zero"}, zero, exp == 64'd0);
    chk1({name, "_ill"}, illegal, exp_ill);
    chk({name, "_tag"}, 64'(out_tag), 64'(exp_tag));
  endtask

  // One op through an otherwise idle pipe with OutReady held high.
  task automatic run_op(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] t, input logic [63:0] exp, input logic exp_ill,
                        input string name);
    out_ready = 1'b1;
    drive(o, a, b, t);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1({name, "_lat"}, out_valid, 1'b0);
    tick();
    chk_out(name, exp, exp_ill, t);
  endtask

  task automatic run32(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic [31:0] exp, input logic exp_ill,
                       input string name);
    v32_op       = o;
    v32_a        = a;
    v32_b        = b;
    v32_in_tag   = t;
    v32_in_valid = 1'b1;
    tick();
    v32_in_valid = 1'b0;
    tick();
    chk1({name, "_valid"}, v32_out_valid, 1'b1);
    chk({name, "_res"}, 64'(v32_result), 64'(exp));
    chk1({name, "_zero"}, v32_zero, exp == 32'd0);
    chk1({name, "_ill"}, v32_illegal, exp_ill);
    chk({name, "_tag"}, 64'(v32_out_tag), 64'(t));
  endtask

  initial begin
    logic [63:0] clz_exp, ctz_exp, cpop_exp;
    logic        cnt_ill;
`ifdef ALU_ZBB_COUNT_EN
    clz_exp = 64'd64; ctz_exp = 64'd3; cpop_exp = 64'd8; cnt_ill = 1'b0;
`else
    clz_exp = 64'd0;  ctz_exp = 64'd0; cpop_exp = 64'd0; cnt_ill = 1'b1;
`endif

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(5'd0, 64'd0, 64'd0, 5'd0);
    v32_in_valid = 1'b0; v32_a = '0; v32_b = '0; v32_op = '0; v32_in_tag = '0;

    #2;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 64'd0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk1("idle_in_ready", in_ready, 1'b1);

    // Main function
    run_op(OpSh2addUw, 64'hFFFF_FFFF_0000_0003, 64'h10, 5'd7, 64'h1C, 1'b0, "sh2add_uw");
    run_op(OpAddw, 64'h7FFF_FFFF, 64'd1, 5'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, "addw");
    run_op(OpSubw, 64'd0, 64'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "subw");
    run_op(OpSlt, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd3, 64'd1, 1'b0, "slt");
    run_op(OpSltu, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 64'd1, 1'b0, "sltu");
    run_op(OpSra, 64'h8000_0000_0000_0000, 64'd63, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "sra");
    run_op(OpSrl, 64'h8000_0000_0000_0000, 64'd63, 5'd6, 64'd1, 1'b0, "srl");
    run_op(OpSub, 64'd5, 64'd5, 5'd8, 64'd0, 1'b0, "sub_zero");
    run_op(OpSh3add, 64'd1, 64'd2, 5'd9, 64'd10, 1'b0, "sh3add");
    run_op(OpSlliUw, 64'hFFFF_FFFF_8000_0001, 64'd4, 5'd10, 64'h8_0000_0010, 1'b0, "slli_uw");
    run_op(OpXor, 64'hFF00, 64'h0FF0, 5'd11, 64'hF0F0, 1'b0, "xor");
    run_op(OpClz, 64'd0, 64'd0, 5'd12, clz_exp, cnt_ill, "clz");
    run_op(OpCtz, 64'h8, 64'd0, 5'd13, ctz_exp, cnt_ill, "ctz");
    run_op(OpCpop, 64'hF0F0, 64'd0, 5'd14, cpop_exp, cnt_ill, "cpop");
    run_op(5'd25, 64'd3, 64'd4, 5'd15, 64'd0, 1'b1, "undef");

    out_ready = 1'b1;
    tick();
    chk1("drained", out_valid, 1'b0);

    // Back-pressure: OutReady low for three cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(OpAdd, 64'd1, 64'd2 - 64'd1, 5'd1);
    #1 chk1("bp_ready0", in_ready, 1'b1);
    tick();
    drive(OpAdd, 64'd2, 64'd3, 5'd2);
    #1 chk1("bp_ready1", in_ready, 1'b1);
    tick();
    drive(OpOr, 64'hF0, 64'h0F, 5'd3);
    #1 chk1("bp_full", in_ready, 1'b0);
    chk_out("bp_head", 64'd2, 1'b0, 5'd1);
    tick();
    chk1("bp_still_full", in_ready, 1'b0);
    chk_out("bp_stable", 64'd2, 1'b0, 5'd1);
    out_ready = 1'b1;
    #1 chk1("bp_drain_accept", in_ready, 1'b1);
    tick();
    drive(OpAnd, 64'hFF, 64'h3C, 5'd4);
    #1 chk_out("bp_op1", 64'd5, 1'b0, 5'd2);
    chk1("bp_ready_flow", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_out("bp_op2", 64'hFF, 1'b0, 5'd3);
    tick();
    chk_out("bp_op3", 64'h3C, 1'b0, 5'd4);
    tick();
    chk1("bp_empty", out_valid, 1'b0);

    // Flush with both stages full and a new op presented
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(OpAdd, 64'd10, 64'd1, 5'd5);
    tick();
    drive(OpAdd, 64'd20, 64'd1, 5'd6);
    tick();
    drive(OpAdd, 64'd30, 64'd1, 5'd9);
    flush     = 1'b1;
    out_ready = 1'b1;
    #1 chk1("flush_in_ready", in_ready, 1'b0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk1("flush_out", out_valid, 1'b0);
    tick();
    chk1("flush_no_accept", out_valid, 1'b0);
    run_op(OpAdd, 64'd3, 64'd4, 5'd11, 64'd7, 1'b0, "post_flush");

    // XLEN=32 instance
    run32(OpAddUw, 32'd5, 32'd6, 5'd3, 32'd0, 1'b1, "x32_add_uw");
    run32(OpAddw, 32'd5, 32'd6, 5'd4, 32'd0, 1'b1, "x32_addw");
    run32(OpAdd, 32'hFFFF_FFFF, 32'd1, 5'd5, 32'd0, 1'b0, "x32_add");
    run32(OpSra, 32'h8000_0000, 32'd31, 5'd6, 32'hFFFF_FFFF, 1'b0, "x32_sra");

    // Reset asserted mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(OpAdd, 64'd1, 64'd2, 5'd12);
    tick();
    drive(OpAdd, 64'd3, 64'd4, 5'd13);
    tick();
    in_valid = 1'b0;
    chk1("mid_full", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk1("mid_rst_ready", in_ready, 1'b0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk1("post_rst_valid0", out_valid, 1'b0);
    tick();
    chk1("post_rst_valid1", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
